// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN  = 2'd1,
      S_HOLD = 2'd2,
      S_WAIT = 2'd3
   } arb_state_t;

   localparam logic [7:0] ASCII_CR = 8'd13;
   localparam logic [7:0] ASCII_LF = 8'd10;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after i_start, wrapping.
module uart_tx_arbiter_rr_pick #(
   parameter int N_REQ = 2,
   parameter int IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_start,
   output logic [N_REQ-1:0] o_win,
   output logic [IW-1:0]    o_idx,
   output logic             o_valid
);

   always_comb begin
      int j;
      j       = 0;
      o_win   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(i_start) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!o_valid && i_req[j]) begin
            o_valid  = 1'b1;
            o_win[j] = 1'b1;
            o_idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmit byte port between N_REQ producers, one message
// per grant, round-robin, with a per-producer busy view.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int         N_REQ        = 2,
   parameter logic [7:0] EOM_BYTE     = ASCII_LF,
   parameter int         IDLE_TIMEOUT = 1023,
   parameter int         HOLD_CYC     = 2
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [N_REQ-1:0]   req_in,
   input  logic [N_REQ*8-1:0] data_in,
   input  logic [N_REQ-1:0]   data_in_en,
   output logic [N_REQ-1:0]   busy_out,
   output logic [N_REQ-1:0]   grant_out,
   output logic [7:0]         tx_data_out,
   output logic               tx_data_out_en,
   input  logic               tx_busy_in,
   output logic               drop_out
);

   localparam int IW = $clog2(N_REQ);
   localparam int SW = $clog2(IDLE_TIMEOUT + 1);
   localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   arb_state_t       r_state;
   logic [N_REQ-1:0] r_grant, r_busy;
   logic [IW-1:0]    r_owner, r_rr;
   logic [7:0]       r_tx_data;
   logic             r_tx_en, r_drop, r_last_eom, r_rel_pend;
   logic [SW-1:0]    r_sil;
   logic [HW-1:0]    r_hold;

   logic [N_REQ-1:0] w_win;
   logic [IW-1:0]    w_win_idx, w_rr_next;
   logic             w_win_vld, w_own_en, w_own_req, w_accept, w_sil_hit, w_release, w_drop;
   logic [7:0]       w_own_byte;

   uart_tx_arbiter_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
      .i_req   (req_in),
      .i_start (r_rr),
      .o_win   (w_win),
      .o_idx   (w_win_idx),
      .o_valid (w_win_vld)
   );

   assign w_own_en   = data_in_en[r_owner];
   assign w_own_req  = req_in[r_owner];
   assign w_own_byte = data_in[{r_owner, 3'b000} +: 8];
   assign w_accept   = (r_state == S_OWN) && w_own_en && !r_busy[r_owner];
   assign w_sil_hit  = !w_own_en && !tx_busy_in && (r_sil == SW'(IDLE_TIMEOUT - 1));
   assign w_rr_next  = (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

   // Any strobe other than the one accepted byte is discarded.
   assign w_drop = |(data_in_en & ~({N_REQ{w_accept}} & r_grant));

   // A byte strobed together with req fall still goes out; release then waits in S_WAIT.
   assign w_release = ((r_state == S_OWN) && !w_accept && (!w_own_req || w_sil_hit)) ||
                      ((r_state == S_WAIT) && !tx_busy_in && (r_last_eom || r_rel_pend));

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_busy     <= '1;
         r_owner    <= '0;
         r_rr       <= '0;
         r_tx_data  <= '0;
         r_tx_en    <= 1'b0;
         r_drop     <= 1'b0;
         r_last_eom <= 1'b0;
         r_rel_pend <= 1'b0;
         r_sil      <= '0;
         r_hold     <= '0;
      end else begin
         r_tx_en <= 1'b0;
         r_drop  <= w_drop;
         if (w_release) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_busy  <= '1;
            r_rr    <= w_rr_next;
         end else begin
            case (r_state)
               S_IDLE: if (w_win_vld) begin
                  r_grant    <= w_win;
                  r_owner    <= w_win_idx;
                  r_busy     <= ~w_win | {N_REQ{tx_busy_in}};
                  r_sil      <= '0;
                  r_rel_pend <= 1'b0;
                  r_state    <= S_OWN;
               end
               S_OWN: if (w_accept) begin
                  r_tx_data  <= w_own_byte;
                  r_tx_en    <= 1'b1;
                  r_busy     <= '1;
                  r_last_eom <= (w_own_byte == EOM_BYTE);
                  r_rel_pend <= !w_own_req;
                  r_sil      <= '0;
                  r_hold     <= '0;
                  r_state    <= S_HOLD;
               end else begin
                  r_busy <= ~r_grant | {N_REQ{tx_busy_in}};
                  if (w_own_en)         r_sil <= '0;
                  else if (!tx_busy_in) r_sil <= r_sil + 1'b1;
               end
               // Covers the transmitter's own latency before its busy rises.
               S_HOLD: if (r_hold == HW'(HOLD_CYC - 1)) r_state <= S_WAIT;
                       else r_hold <= r_hold + 1'b1;
               S_WAIT: if (!tx_busy_in) begin
                  r_busy  <= ~r_grant;
                  r_state <= S_OWN;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy_out       = r_busy;
   assign grant_out      = r_grant;
   assign tx_data_out    = r_tx_data;
   assign tx_data_out_en = r_tx_en;
   assign drop_out       = r_drop;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter byte port between N_REQ byte-stream producers (BCD display formatter, status/debug message sources).
- Grants the transmitter to one requester per message, with round-robin fairness, and holds the grant until the message-terminating byte has left the transmitter.
- Gives each producer its own busy view, so a producer's existing "send byte, wait for !busy" loop works unchanged.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- EOM_BYTE, 8'd10, byte that ends a message (LF); grant is released after it is transmitted.
- IDLE_TIMEOUT, 1023, cycles the owner may stay silent (no byte, transmitter idle) before its grant is revoked.
- HOLD_CYC, 2, cycles owner busy is forced high after a forwarded byte, covering transmitter busy-rise latency.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset; synchronous, active-low.
- req_in  in  N_REQ  per-requester message request; level, held for the whole message.
- data_in  in  N_REQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- data_in_en  in  N_REQ  per-requester one-cycle byte strobe.
- busy_out  out  N_REQ  per-requester busy; 1 = do not strobe.
- grant_out  out  N_REQ  one-hot current owner; all-zero when no owner.
- tx_data_out  out  8  byte to the UART transmitter.
- tx_data_out_en  out  1  one-cycle strobe to the transmitter.
- tx_busy_in  in  1  transmitter busy.
- drop_out  out  1  one-cycle pulse when a strobe is discarded.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge):
  - state=S_IDLE; grant_out=0; tx_data_out=0; tx_data_out_en=0; drop_out=0; busy_out=all 1; rr pointer=0; counters=0.
  - Reset mid-message abandons the message. No partial strobe is emitted after reset.
- All outputs are registered.
- busy_out[i] = 1 for every i that is not the owner, in all states.
- S_IDLE:
  - Search req_in starting at index rr, wrapping; first set bit wins.
  - With a winner: next cycle grant_out=onehot(winner), state=S_OWN, owner busy=tx_busy_in registered. Request-to-grant latency is 1 cycle.
  - No request: stay in S_IDLE.
- S_OWN:
  - Owner data_in_en=1 with owner busy_out=0: next cycle tx_data_out=byte, tx_data_out_en=1 (exactly 1 cycle). Owner busy_out goes 1 in the same cycle; state=S_HOLD. Latch last_eom = (byte==EOM_BYTE).
  - Owner req_in=0: release.
  - Silence counter increments each cycle with no owner strobe and tx_busy_in=0. When it reaches IDLE_TIMEOUT: release. The counter clears on any owner strobe.
- S_HOLD:
  - Owner busy_out held at 1 for HOLD_CYC cycles, then follows tx_busy_in; state=S_WAIT.
- S_WAIT:
  - When tx_busy_in=0:
    - last_eom=1: release.
    - last_eom=0: owner busy_out=0, state=S_OWN.
- Release: grant_out=0, all busy_out=1, rr=(owner+1) mod N_REQ, state=S_IDLE. At least 1 idle cycle always separates grants; the same requester may regain the grant only if no other requester is asserting.
- Drops: data_in_en from a non-owner, or from the owner while its busy_out=1, is discarded and drop_out pulses the next cycle. Multiple simultaneous drops produce a single pulse.
- Simultaneous owner strobe and owner req_in fall in the same cycle: the byte is forwarded, and release happens after it completes (via S_HOLD/S_WAIT).
- Owner req_in remains high after the EOM byte: the grant is still released; the owner re-arbitrates.

Decomposition:
- Shared package g: typedef arb_state_t {S_IDLE,S_OWN,S_HOLD,S_WAIT}; localparams ASCII_CR=8'd13, ASCII_LF=8'd10.
- Sub-module rr_pick (combinational): N_REQ request vector plus start index → one-hot winner and valid. Everything else stays in uart_tx_arbiter.

Test Plan:
- Single requester 0 sends "123\r\n", with the transmitter model busy 10 cycles/byte starting 1 cycle after strobe → tx sees 0x31,0x32,0x33,0x0D,0x0A in order; grant_out=01 throughout, then 00 after LF completes; drop_out never asserted.
- req_in=11 asserted in the same cycle at reset exit → requester 0 granted first, requester 1 granted after 0's LF plus 1 idle cycle. Repeat with both held → grants alternate 0,1,0,1.
- Requester 1 strobes 0x41 while requester 0 owns → byte not forwarded, drop_out pulses once, busy_out[1]=1 throughout.
- Owner strobes a second byte during S_HOLD (HOLD_CYC=2) → second byte dropped, drop_out pulse, only the first byte reaches tx.
- Owner holds req_in with no strobes, IDLE_TIMEOUT=15 → grant revoked after exactly 15 silent cycles, pending requester 1 granted next.
- Reset asserted for 1 cycle between bytes 2 and 3 of a message → all outputs at reset values next cycle, no further tx strobes until a new request.
